// File: rtl/jk_driver.sv
// -----------------------------------------------------------------------------
// jk_driver
//   Drives the j/k inputs of an external positive-edge JK flip-flop so that its
//   q output follows a requested bit pattern, then checks q against the pattern.
//   Pattern words arrive over a valid/ready handshake and are played out LSB
//   first, one bit per clock. Each driven bit travels down a two-entry check
//   pipeline and is compared with the sampled q two edges after its j/k were
//   registered. Failed compares pulse `mismatch`, record the bit index and bump
//   a saturating error counter.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous reset, active high
//   in_valid     pattern word available
//   in_ready     driver accepts a word this cycle
//   in_data      pattern word, bit 0 is driven first
//   j, k         registered J/K drive to the flip-flop
//   q_in         q output of the flip-flop
//   busy         word in flight or check pipeline non-empty
//   done         one-cycle pulse when the last bit of a word has been checked
//   mismatch     one-cycle pulse on a failed bit check
//   mismatch_idx bit index of the most recent mismatch
//   err_cnt      saturating mismatch count since reset
// -----------------------------------------------------------------------------
module jk_driver #(
  parameter int  WIDTH       = 8,
  parameter int  CNT_W       = 16,
  parameter bit  TOGGLE_PREF = 1'b0,
  localparam int IDX_W       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [IDX_W-1:0] mismatch_idx,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_DRIVE
  } state_e;

  // One check-pipeline entry: the bit that was driven and where it sits in its word.
  typedef struct packed {
    logic             valid;
    logic             d;
    logic [IDX_W-1:0] idx;
    logic             last;
  } chk_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             model_q, model_d;   // q the flip-flop should hold once j/k land
  logic             j_q, j_d, k_q, k_d;
  chk_t             pipe0_q, pipe0_d;   // registered with j/k, flip-flop captures next edge
  chk_t             pipe1_q, pipe1_d;   // compared against q_in on the following edge
  logic             done_q, done_d;
  logic             mm_q, mm_d;
  logic [IDX_W-1:0] mm_idx_q, mm_idx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             bit_d;
  logic             last_bit;

  // JK excitation for a transition cur -> nxt, returned as {j, k}.
  function automatic logic [1:0] excite(input logic cur, input logic nxt);
    if (cur == nxt) return 2'b00;
    if (TOGGLE_PREF) return 2'b11;
    return nxt ? 2'b10 : 2'b01;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    model_d  = model_q;
    j_d      = 1'b0;
    k_d      = 1'b0;
    in_ready = 1'b0;
    pipe0_d  = '0;
    bit_d    = shreg_q[0];
    last_bit = (cnt_q == LAST_IDX);

    unique case (state_q)
      ST_INIT: begin
        // Force the flip-flop to a known 0 before any pattern is played.
        k_d     = 1'b1;
        model_d = 1'b0;
        state_d = ST_IDLE;
      end

      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        // Excitation comes from the model q, never q_in, so a faulty
        // flip-flop cannot disturb the drive sequence.
        {j_d, k_d} = excite(model_q, bit_d);
        model_d    = bit_d;
        pipe0_d    = '{valid: 1'b1, d: bit_d, idx: cnt_q, last: last_bit};
        shreg_d    = shreg_q >> 1;
        cnt_d      = cnt_q + 1'b1;
        if (last_bit) begin
          // Last bit: take the next word now so back-to-back words have no gap.
          in_ready = 1'b1;
          if (in_valid) begin
            shreg_d = in_data;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_INIT;
    endcase

    // Check stage: the entry in pipe1 had its j/k captured by the flip-flop
    // on the previous edge, so q_in now shows the result.
    pipe1_d  = pipe0_q;
    done_d   = 1'b0;
    mm_d     = 1'b0;
    mm_idx_d = mm_idx_q;
    err_d    = err_q;
    if (pipe1_q.valid) begin
      done_d = pipe1_q.last;
      if (q_in != pipe1_q.d) begin
        mm_d     = 1'b1;
        mm_idx_d = pipe1_q.idx;
        if (err_q != '1) err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= ST_INIT;
      shreg_q  <= '0;
      cnt_q    <= '0;
      model_q  <= 1'b0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      pipe0_q  <= '0;
      pipe1_q  <= '0;
      done_q   <= 1'b0;
      mm_q     <= 1'b0;
      mm_idx_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      model_q  <= model_d;
      j_q      <= j_d;
      k_q      <= k_d;
      pipe0_q  <= pipe0_d;
      pipe1_q  <= pipe1_d;
      done_q   <= done_d;
      mm_q     <= mm_d;
      mm_idx_q <= mm_idx_d;
      err_q    <= err_d;
    end
  end

  assign j            = j_q;
  assign k            = k_q;
  assign busy         = (state_q == ST_DRIVE) | pipe0_q.valid | pipe1_q.valid;
  assign done         = done_q;
  assign mismatch     = mm_q;
  assign mismatch_idx = mm_idx_q;
  assign err_cnt      = err_q;

endmodule

// File: doc/jk_driver.md
Name: jk_driver

Overview:
- Drives the j/k inputs of an external positive-edge JK flip-flop so that its q output follows a requested bit pattern.
- Accepts WIDTH-bit pattern words over a valid/ready handshake and serialises them LSB first, one bit per clock.
- Computes the JK excitation for each bit, samples the flip-flop's q and checks it against the expected value.
- Counts mismatches. Serves as the stimulus and check end of the flip-flop interface in self-checking benches and BIST-style wrappers.

Parameters:
- WIDTH, 8, pattern word width in bits (>=2).
- CNT_W, 16, width of the saturating error counter.
- TOGGLE_PREF, 0: 0 = state changes use set/reset excitation; 1 = state changes use toggle (j=k=1).

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  pattern word available
- in_ready  output  1  driver accepts word this cycle
- in_data  input  WIDTH  pattern word; bit 0 is driven first
- j  output  1  J input to the flip-flop (registered)
- k  output  1  K input to the flip-flop (registered)
- q_in  input  1  q output of the flip-flop
- busy  output  1  word in flight or check pipeline non-empty
- done  output  1  one-cycle pulse when the last bit of a word has been checked
- mismatch  output  1  one-cycle pulse on a failed bit check
- mismatch_idx  output  clog2(WIDTH)  bit index of the most recent mismatch
- err_cnt  output  CNT_W  saturating mismatch count since reset

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: j=0, k=0, in_ready=0, busy=0, done=0, mismatch=0, mismatch_idx=0, err_cnt=0. State goes to INIT, the model q is cleared and the check pipeline is flushed.
- States:
  - INIT: one cycle, drives j=0, k=1 to force the flip-flop to 0. Model q=0. Next state IDLE. No check is scheduled.
  - IDLE: in_ready=1, j=0, k=0 (hold). When in_valid&&in_ready, in_data is captured into the shift register, bit counter = 0, next state DRIVE.
  - DRIVE: each cycle takes target bit d = shreg[0]. It registers j/k from (model q, d), sets model q = d, shifts right, increments the counter, and pushes (d, idx, last) into the check pipeline. On the cycle the bit with idx WIDTH-1 is driven, in_ready=1:
    - with in_valid, the next word loads and DRIVE continues with no gap;
    - without in_valid, next state IDLE.
- Excitation with TOGGLE_PREF=0:
  - 0->0: j=0, k=0
  - 0->1: j=1, k=0
  - 1->0: j=0, k=1
  - 1->1: j=0, k=0
- Excitation with TOGGLE_PREF=1: 0->1 and 1->0 both drive j=1, k=1; holds unchanged.
- Excitation is computed from the model q, never from q_in, so drive is free of feedback from faults.
- Check latency:
  - j/k for bit i are registered at edge t.
  - The flip-flop captures them at edge t+1.
  - The driver samples q_in at edge t+2 and compares it with d_i.
  - The check pipeline is therefore 2 entries deep.
- Mismatch:
  - mismatch=1 and mismatch_idx=i in the cycle after the compare edge.
  - err_cnt increments by 1 and saturates at 2^CNT_W-1; it is never cleared except by rst.
- done:
  - Pulses in the same cycle as the check result of an entry flagged last, whether it passed or failed.
  - Back-to-back words give one done per word.
- busy: 1 from load until the last pipeline entry retires; 0 in INIT and steady IDLE.
- Simultaneous events: a load in the last-bit cycle and a retiring check in the same cycle are both honoured.
- Reset mid-word: the word is discarded and nothing further is checked for it. Reset values apply on the next edge, then INIT.
- in_data is ignored when the handshake does not fire.

Test Plan:
- Reset then release, ideal JK model -> j=0,k=1 for exactly one cycle, then j=0,k=0 and in_ready=1; q_in=0; err_cnt=0.
- TOGGLE_PREF=0, send 8'b10110010 -> (j,k) per bit = 00,10,01,00,10,00,01,10; q follows the pattern; one done pulse 2 cycles after the last drive; err_cnt=0.
- TOGGLE_PREF=1, same word -> every state change drives j=k=1; q pattern and err_cnt=0 unchanged.
- Back-to-back 8'hA5 then 8'h3C with in_valid held -> in_ready high only on last-bit cycles, 16 consecutive drive cycles, two done pulses 8 cycles apart, err_cnt=0.
- Bench forces q_in=0 (stuck-at-0), send 8'hFF -> mismatch pulses on 8 consecutive cycles with mismatch_idx 0..7; err_cnt=8; done still pulses.
- CNT_W=3 with stuck-at-0 and two 8'hFF words -> err_cnt saturates at 7. Then assert rst during bit 3 of a further word -> no further mismatch/done, err_cnt=0, INIT cycle, then IDLE.
